data_memo_arbiter: RTL and testbench

Two-port arbiter and sequencer in front of the single-port data memory (32 words, 6-bit address). It shares the memory between the core's load/store port (cpu) and the debug/loader port (dbg) using valid/ready request handshakes. It drives the memory's address, write data and read/write enables, and returns registered read responses one cycle after acceptance. A starvation counter bounds how long dbg can wait behind cpu.

---
 rtl/data_memo_arbiter_if.sv | 25 ++
 rtl/data_memo_arbiter.sv | 129 ++++++++++++
 tb/tb_data_memo_arbiter.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/data_memo_arbiter_if.sv
// Request/response bundle for one data-memory client port.
// master = requester (core or debug loader), slave = arbiter side.
interface data_memo_arbiter_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/data_memo_arbiter.sv
// Arbiter/sequencer sharing one data memory between cpu and dbg ports.
// Ports: clk, rst_n, cpu/dbg client bundles, mem_* memory drive and read data.
module data_memo_arbiter #(
    parameter int ADDR_W   = 6,
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    data_memo_arbiter_if.slave  cpu,
    data_memo_arbiter_if.slave  dbg,
    output logic [ADDR_W-1:0]   mem_address,
    output logic [DATA_W-1:0]   mem_input_data,
    output logic                mem_enable_read,
    output logic                mem_enable_write,
    input  logic [DATA_W-1:0]   mem_read_data
);

    // Extra bit so DEPTH == 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0] DEPTH_C    = (ADDR_W+1)'(DEPTH);
    localparam logic [3:0]      MAX_WAIT_C = 4'(MAX_WAIT);

    logic [3:0]        wait_cnt_q, wait_cnt_d;
    logic              force_dbg;
    logic              gnt_cpu, gnt_dbg, gnt_any;
    logic              sel_write, sel_in_range;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    logic              cpu_rsp_valid_q, cpu_rsp_valid_d;
    logic [DATA_W-1:0] cpu_rsp_rdata_q, cpu_rsp_rdata_d;
    logic              cpu_rsp_err_q, cpu_rsp_err_d;
    logic              dbg_rsp_valid_q, dbg_rsp_valid_d;
    logic [DATA_W-1:0] dbg_rsp_rdata_q, dbg_rsp_rdata_d;
    logic              dbg_rsp_err_q, dbg_rsp_err_d;

    // Grant: a starved dbg beats cpu; otherwise cpu has priority.
    // rst_n gates the grant so nothing is accepted while in reset.
    always_comb begin
        force_dbg = dbg.req_valid && (wait_cnt_q == MAX_WAIT_C);
        gnt_dbg   = rst_n && dbg.req_valid && (force_dbg || !cpu.req_valid);
        gnt_cpu   = rst_n && cpu.req_valid && !force_dbg;
        gnt_any   = gnt_cpu || gnt_dbg;
    end

    always_comb begin
        sel_write = cpu.req_write;
        sel_addr  = cpu.req_addr;
        sel_wdata = cpu.req_wdata;
        if (gnt_dbg) begin
            sel_write = dbg.req_write;
            sel_addr  = dbg.req_addr;
            sel_wdata = dbg.req_wdata;
        end
        sel_in_range = {1'b0, sel_addr} < DEPTH_C;
    end

    always_comb begin
        mem_address      = '0;
        mem_input_data   = '0;
        mem_enable_write = 1'b0;
        mem_enable_read  = 1'b0;
        if (gnt_any && sel_in_range) begin
            mem_address      = sel_addr;
            mem_input_data   = sel_wdata;
            mem_enable_write = sel_write;
            mem_enable_read  = !sel_write;
        end
    end

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!dbg.req_valid || gnt_dbg) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q != MAX_WAIT_C) begin
            wait_cnt_d = wait_cnt_q + 4'd1;
        end
    end

    // Responses: valid pulses for one cycle, data/err hold until the
    // next response on the same port.
    always_comb begin
        cpu_rsp_valid_d = gnt_cpu && !sel_write;
        cpu_rsp_rdata_d = cpu_rsp_rdata_q;
        cpu_rsp_err_d   = cpu_rsp_err_q;
        if (cpu_rsp_valid_d) begin
            cpu_rsp_rdata_d = sel_in_range ? mem_read_data : '0;
            cpu_rsp_err_d   = !sel_in_range;
        end
        dbg_rsp_valid_d = gnt_dbg && !sel_write;
        dbg_rsp_rdata_d = dbg_rsp_rdata_q;
        dbg_rsp_err_d   = dbg_rsp_err_q;
        if (dbg_rsp_valid_d) begin
            dbg_rsp_rdata_d = sel_in_range ? mem_read_data : '0;
            dbg_rsp_err_d   = !sel_in_range;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q      <= '0;
            cpu_rsp_valid_q <= 1'b0;
            cpu_rsp_rdata_q <= '0;
            cpu_rsp_err_q   <= 1'b0;
            dbg_rsp_valid_q <= 1'b0;
            dbg_rsp_rdata_q <= '0;
            dbg_rsp_err_q   <= 1'b0;
        end else begin
            wait_cnt_q      <= wait_cnt_d;
            cpu_rsp_valid_q <= cpu_rsp_valid_d;
            cpu_rsp_rdata_q <= cpu_rsp_rdata_d;
            cpu_rsp_err_q   <= cpu_rsp_err_d;
            dbg_rsp_valid_q <= dbg_rsp_valid_d;
            dbg_rsp_rdata_q <= dbg_rsp_rdata_d;
            dbg_rsp_err_q   <= dbg_rsp_err_d;
        end
    end

    assign cpu.req_ready = gnt_cpu;
    assign cpu.rsp_valid = cpu_rsp_valid_q;
    assign cpu.rsp_rdata = cpu_rsp_rdata_q;
    assign cpu.rsp_err   = cpu_rsp_err_q;
    assign dbg.req_ready = gnt_dbg;
    assign dbg.rsp_valid = dbg_rsp_valid_q;
    assign dbg.rsp_rdata = dbg_rsp_rdata_q;
    assign dbg.rsp_err   = dbg_rsp_err_q;

endmodule

// File: tb/tb_data_memo_arbiter.sv
// Randomized bench for data_memo_arbiter against a behavioural model.
// Holds a device memory plus an independent shadow memory for expectations.
module tb_data_memo_arbiter;

    localparam int ADDR_W   = 6;
    localparam int DATA_W   = 32;
    localparam int DEPTH    = 32;
    localparam int MAX_WAIT = 4;

    typedef struct packed {
        logic        valid;
        logic        write;
        logic [5:0]  addr;
        logic [31:0] wdata;
    } req_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    data_memo_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) cpu_if ();
    data_memo_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dbg_if ();

    logic [5:0]  mem_address;
    logic [31:0] mem_input_data;
    logic [31:0] mem_read_data;
    logic        mem_enable_read;
    logic        mem_enable_write;

    data_memo_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .cpu              (cpu_if),
        .dbg              (dbg_if),
        .mem_address      (mem_address),
        .mem_input_data   (mem_input_data),
        .mem_enable_read  (mem_enable_read),
        .mem_enable_write (mem_enable_write),
        .mem_read_data    (mem_read_data)
    );

    // Device memory: combinational read, synchronous write.
    logic [31:0] dev_mem [DEPTH];
    assign mem_read_data = (mem_address < 6'd32) ? dev_mem[mem_address[4:0]] : '0;
    always @(posedge clk) begin
        if (mem_enable_write) dev_mem[mem_address[4:0]] <= mem_input_data;
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model state
    req_t        cr, dr;
    int          m_wait;
    logic [31:0] m_mem [DEPTH];
    logic        e_cv, e_cerr, e_dv, e_derr;
    logic [31:0] e_crd, e_drd;
    bit          acc_c, acc_d;
    int          n_dgnt;

    task automatic drive();
        cpu_if.req_valid = cr.valid;
        cpu_if.req_write = cr.write;
        cpu_if.req_addr  = cr.addr;
        cpu_if.req_wdata = cr.wdata;
        dbg_if.req_valid = dr.valid;
        dbg_if.req_write = dr.write;
        dbg_if.req_addr  = dr.addr;
        dbg_if.req_wdata = dr.wdata;
    endtask

    task automatic chk_rsp();
        chk("cpu_rsp_valid", 32'(cpu_if.rsp_valid), 32'(e_cv));
        chk("cpu_rsp_rdata", cpu_if.rsp_rdata, e_crd);
        chk("cpu_rsp_err", 32'(cpu_if.rsp_err), 32'(e_cerr));
        chk("dbg_rsp_valid", 32'(dbg_if.rsp_valid), 32'(e_dv));
        chk("dbg_rsp_rdata", dbg_if.rsp_rdata, e_drd);
        chk("dbg_rsp_err", 32'(dbg_if.rsp_err), 32'(e_derr));
    endtask

    // Called 1ns after a rising edge with requests already driven.
    task automatic run_cycle(input bit do_rst);
        bit   gc, gd, any, inr;
        req_t g;
        if (do_rst) begin
            rst_n = 1'b0;
            #4;
            m_wait = 0;
            e_cv = 0; e_crd = '0; e_cerr = 0;
            e_dv = 0; e_drd = '0; e_derr = 0;
            chk("rst_cpu_ready", 32'(cpu_if.req_ready), 32'd0);
            chk("rst_dbg_ready", 32'(dbg_if.req_ready), 32'd0);
            chk("rst_mem_wen", 32'(mem_enable_write), 32'd0);
            chk("rst_mem_ren", 32'(mem_enable_read), 32'd0);
            chk_rsp();
            acc_c = 0;
            acc_d = 0;
            @(posedge clk);
            #1;
            rst_n = 1'b1;
        end else begin
            gd  = dr.valid && (m_wait == MAX_WAIT || !cr.valid);
            gc  = cr.valid && !gd;
            any = gc || gd;
            g   = gd ? dr : cr;
            inr = g.addr < 6'(DEPTH);
            #4;
            chk("cpu_ready", 32'(cpu_if.req_ready), 32'(gc));
            chk("dbg_ready", 32'(dbg_if.req_ready), 32'(gd));
            chk("mem_wen", 32'(mem_enable_write), 32'(any && g.write && inr));
            chk("mem_ren", 32'(mem_enable_read), 32'(any && !g.write && inr));
            chk("mem_addr", 32'(mem_address), (any && inr) ? 32'(g.addr) : 32'd0);
            chk("mem_wdata", mem_input_data, (any && inr) ? g.wdata : 32'd0);
            chk_rsp();
            e_cv = gc && !cr.write;
            if (e_cv) begin
                e_crd  = inr ? m_mem[cr.addr[4:0]] : '0;
                e_cerr = !inr;
            end
            e_dv = gd && !dr.write;
            if (e_dv) begin
                e_drd  = inr ? m_mem[dr.addr[4:0]] : '0;
                e_derr = !inr;
            end
            if (any && g.write && inr) m_mem[g.addr[4:0]] = g.wdata;
            if (dr.valid && !gd) m_wait = (m_wait < MAX_WAIT) ? m_wait + 1 : MAX_WAIT;
            else m_wait = 0;
            if (gd) n_dgnt++;
            acc_c = gc;
            acc_d = gd;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic next_req(inout req_t r, input bit acc, input int pv);
        if (!r.valid || acc) begin
            r.valid = ($urandom_range(99) < pv);
            r.write = 1'($urandom_range(1));
            if ($urandom_range(7) == 0) r.addr = 6'($urandom_range(63, 32));
            else r.addr = 6'($urandom_range(31));
            r.wdata = $urandom;
        end
    endtask

    task automatic op(input bit on_dbg, input bit wr, input logic [5:0] a, input logic [31:0] d);
        req_t r;
        r = '{valid: 1'b1, write: wr, addr: a, wdata: d};
        cr = '0;
        dr = '0;
        if (on_dbg) dr = r;
        else cr = r;
        drive();
        run_cycle(0);
    endtask

    task automatic idle();
        cr = '0;
        dr = '0;
        drive();
        run_cycle(0);
    endtask

    initial begin
        cr = '0;
        dr = '0;
        acc_c = 0;
        acc_d = 0;
        n_dgnt = 0;
        m_wait = 0;
        drive();
        @(posedge clk);
        #1;
        cr.valid = 1'b1;
        dr.valid = 1'b1;
        drive();
        run_cycle(1);

        for (int i = 0; i < DEPTH; i++) op(0, 1, 6'(i), 32'h10 + 32'(i));

        op(0, 1, 6'd5, 32'hDEADBEEF);
        op(0, 0, 6'd5, 32'h0);
        chk("rd_after_wr_valid", 32'(cpu_if.rsp_valid), 32'd1);
        chk("rd_after_wr_data", cpu_if.rsp_rdata, 32'hDEADBEEF);

        for (int i = 0; i < 4; i++) op(0, 0, 6'(i), 32'h0);
        idle();

        op(1, 0, 6'd40, 32'h0);
        op(1, 0, 6'd7, 32'h0);
        idle();

        op(0, 0, 6'd9, 32'h0);
        cr = '0;
        drive();
        run_cycle(1);
        idle();
        chk("dropped_rsp", 32'(cpu_if.rsp_valid), 32'd0);
        op(0, 0, 6'd9, 32'h0);
        idle();

        n_dgnt = 0;
        for (int i = 0; i < 25; i++) begin
            next_req(cr, acc_c, 100);
            next_req(dr, acc_d, 100);
            drive();
            run_cycle(0);
        end
        chk("dbg_grant_count", 32'(n_dgnt), 32'd5);

        drive();
        run_cycle(1);
        drive();
        run_cycle(0);

        for (int i = 0; i < 600; i++) begin
            next_req(cr, acc_c, 60);
            next_req(dr, acc_d, 60);
            drive();
            run_cycle($urandom_range(99) == 0);
        end
        idle();
        idle();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
